riscv_multi_ctrl: RTL and testbench

//  Multicycle sequencer for the RV32I core with one shared instruction/data memory port.

---
 rtl/riscv_multi_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_riscv_multi_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multi_ctrl.sv
// Multicycle RV32I control sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath enables and selects.
// The memory port is shared between fetch and data accesses via req/ready.
module riscv_multi_ctrl #(
  parameter int P_MEM_TO = 255,  // max ready wait cycles; 0 disables timeout
  parameter int P_CNT_W  = 8     // wait counter width
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5b,
  input  logic       i_alu_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_wr_en,
  output logic       o_src_addr,
  output logic       o_ir_wr_en,
  output logic       o_pc_wr_en,
  output logic [1:0] o_src_pc,
  output logic [1:0] o_src_alu_a,
  output logic [1:0] o_src_alu_b,
  output logic [3:0] o_alu_ctrl,
  output logic       o_reg_wr_en,
  output logic [1:0] o_src_rd,
  output logic       o_retire,
  output logic       o_err,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXE_R = 4'd2,  S_EXE_I = 4'd3,
    S_MEM_ADR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WB = 4'd6, S_MEM_WR = 4'd7,
    S_ALU_WB = 4'd8, S_BRANCH = 4'd9,  S_JAL = 4'd10,   S_JALR = 4'd11,
    S_LUI = 4'd12,   S_AUIPC = 4'd13,  S_ERR = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes shared with the core ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  state_t             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               mem_busy;
  logic               br_legal;
  logic               br_take;

  // funct3 -> ALU op; SUB only for R-type, SRA whenever funct7[5] is set
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                             input logic f7, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch legality and take decision from funct3 and the ALU zero flag
  always_comb begin
    br_legal = (i_funct3[2:1] != 2'b01);
    case (i_funct3)
      3'b000, 3'b101, 3'b111: br_take = i_alu_zero;
      default:                br_take = ~i_alu_zero;
    endcase
  end

  // Next state, wait counter and sticky error
  always_comb begin
    state_d  = state_q;
    mem_busy = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    case (state_q)
      S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_R:               state_d = S_EXE_R;
          OP_I:               state_d = S_EXE_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default:            state_d = S_ERR;
        endcase
      end
      S_EXE_R, S_EXE_I, S_AUIPC: state_d = S_ALU_WB;
      S_MEM_ADR: state_d = (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (i_mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:  if (i_mem_ready) state_d = S_FETCH;
      S_BRANCH:  state_d = br_legal ? S_FETCH : S_ERR;
      S_ALU_WB, S_MEM_WB, S_JAL, S_JALR, S_LUI: state_d = S_FETCH;
      default:   state_d = S_ERR;
    endcase
    // A stalled access that has used up its wait budget aborts
    if (P_MEM_TO != 0 && mem_busy && !i_mem_ready && cnt_q == P_CNT_W'(P_MEM_TO))
      state_d = S_ERR;
    if (state_d != state_q)
      cnt_d = '0;
    else if (mem_busy && !i_mem_ready)
      cnt_d = cnt_q + P_CNT_W'(1);
    else
      cnt_d = cnt_q;
    err_d = err_q | (state_d == S_ERR);
  end

  // State, wait counter and error flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore decode of datapath controls; fetch/store completion strobes follow ready
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wr_en = 1'b0;
    o_src_addr  = 1'b0;
    o_ir_wr_en  = 1'b0;
    o_pc_wr_en  = 1'b0;
    o_src_pc    = 2'd0;
    o_src_alu_a = 2'd0;
    o_src_alu_b = 2'd0;
    o_alu_ctrl  = ALU_ADD;
    o_reg_wr_en = 1'b0;
    o_src_rd    = 2'd0;
    o_retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_ir_wr_en = i_mem_ready;
        o_pc_wr_en = i_mem_ready;
      end
      S_EXE_R: o_alu_ctrl = alu_from_f3(i_funct3, i_funct7_5b, 1'b1);
      S_EXE_I: begin
        o_src_alu_b = 2'd1;
        o_alu_ctrl  = alu_from_f3(i_funct3, i_funct7_5b, 1'b0);
      end
      S_MEM_ADR: o_src_alu_b = 2'd1;
      S_MEM_RD: begin
        o_mem_req  = 1'b1;
        o_src_addr = 1'b1;
      end
      S_MEM_WB: begin
        o_reg_wr_en = 1'b1;
        o_src_rd    = 2'd1;
        o_retire    = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_req   = 1'b1;
        o_mem_wr_en = 1'b1;
        o_src_addr  = 1'b1;
        o_retire    = i_mem_ready;
      end
      S_ALU_WB: begin
        o_reg_wr_en = 1'b1;
        o_retire    = 1'b1;
      end
      S_BRANCH: begin
        o_alu_ctrl = (i_funct3[2:1] == 2'b00) ? ALU_SUB :
                     (i_funct3[1] ? ALU_SLTU : ALU_SLT);
        o_src_pc   = 2'd1;
        o_pc_wr_en = br_legal & br_take;
        o_retire   = br_legal;
      end
      S_JAL: begin
        o_pc_wr_en  = 1'b1;
        o_src_pc    = 2'd1;
        o_reg_wr_en = 1'b1;
        o_src_rd    = 2'd2;
        o_retire    = 1'b1;
      end
      S_JALR: begin
        o_src_alu_b = 2'd1;
        o_pc_wr_en  = 1'b1;
        o_src_pc    = 2'd2;
        o_reg_wr_en = 1'b1;
        o_src_rd    = 2'd2;
        o_retire    = 1'b1;
      end
      S_LUI: begin
        o_reg_wr_en = 1'b1;
        o_src_rd    = 2'd3;
        o_retire    = 1'b1;
      end
      S_AUIPC: begin
        o_src_alu_a = 2'd1;
        o_src_alu_b = 2'd1;
      end
      default: ;
    endcase
    // Reset overrides any completing access: no architectural write this cycle
    if (i_rst) begin
      o_ir_wr_en  = 1'b0;
      o_pc_wr_en  = 1'b0;
      o_reg_wr_en = 1'b0;
      o_retire    = 1'b0;
    end
  end

  assign o_err   = err_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Directed bench for riscv_multi_ctrl: walks each instruction class through
// the sequencer and checks state and control outputs cycle by cycle.
module tb_riscv_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7;
  logic       zero;
  logic       ready;
  logic       mem_req, mem_wr_en, src_addr, ir_wr_en, pc_wr_en;
  logic [1:0] src_pc, src_a, src_b, src_rd;
  logic [3:0] alu_ctrl, state;
  logic       reg_wr_en, retire, err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  riscv_multi_ctrl #(.P_MEM_TO(4), .P_CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_opcode    (opcode),
    .i_funct3    (f3),
    .i_funct7_5b (f7),
    .i_alu_zero  (zero),
    .i_mem_ready (ready),
    .o_mem_req   (mem_req),
    .o_mem_wr_en (mem_wr_en),
    .o_src_addr  (src_addr),
    .o_ir_wr_en  (ir_wr_en),
    .o_pc_wr_en  (pc_wr_en),
    .o_src_pc    (src_pc),
    .o_src_alu_a (src_a),
    .o_src_alu_b (src_b),
    .o_alu_ctrl  (alu_ctrl),
    .o_reg_wr_en (reg_wr_en),
    .o_src_rd    (src_rd),
    .o_retire    (retire),
    .o_err       (err),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] fn3, input logic fn7);
    opcode = op;
    f3     = fn3;
    f7     = fn7;
  endtask

  // FETCH with memory ready immediately
  task automatic do_fetch(input string tag);
    ready = 1'b1;
    #1;
    chk({tag, "_f_state"}, state, 0);
    chk({tag, "_f_req"}, mem_req, 1);
    chk({tag, "_f_addr"}, src_addr, 0);
    chk({tag, "_f_ir"}, ir_wr_en, 1);
    chk({tag, "_f_pc"}, pc_wr_en, 1);
    chk({tag, "_f_srcpc"}, src_pc, 0);
    tick();
  endtask

  task automatic do_decode(input string tag);
    chk({tag, "_d_state"}, state, 1);
    chk({tag, "_d_req"}, mem_req, 0);
    chk({tag, "_d_strobes"}, {reg_wr_en, pc_wr_en, retire}, 0);
    tick();
  endtask

  // ALU instruction: FETCH, DECODE, EXE, ALU_WB, back to FETCH
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] fn3,
                         input logic fn7, input int exe_st, input int exp_alu, input int exp_b);
    set_ir(op, fn3, fn7);
    start = cyc;
    do_fetch(tag);
    do_decode(tag);
    chk({tag, "_x_state"}, state, exe_st);
    chk({tag, "_x_alu"}, alu_ctrl, exp_alu);
    chk({tag, "_x_a"}, src_a, 0);
    chk({tag, "_x_b"}, src_b, exp_b);
    chk({tag, "_x_reg"}, reg_wr_en, 0);
    tick();
    chk({tag, "_wb_state"}, state, 8);
    chk({tag, "_wb_reg"}, reg_wr_en, 1);
    chk({tag, "_wb_rd"}, src_rd, 0);
    chk({tag, "_wb_retire"}, retire, 1);
    tick();
    chk({tag, "_cpi"}, cyc - start, 4);
    chk({tag, "_next"}, state, 0);
    $display("[TB] %s op=%b f3=%b f7=%b alu=%0d", tag, op, fn3, fn7, exp_alu);
  endtask

  task automatic run_br(input string tag, input logic [2:0] fn3, input logic z,
                        input int exp_alu, input int exp_take);
    set_ir(OP_BRANCH, fn3, 1'b0);
    start = cyc;
    do_fetch(tag);
    do_decode(tag);
    zero = z;
    #1;
    chk({tag, "_state"}, state, 9);
    chk({tag, "_alu"}, alu_ctrl, exp_alu);
    chk({tag, "_ab"}, {src_a, src_b}, 0);
    chk({tag, "_pcwr"}, pc_wr_en, exp_take);
    chk({tag, "_srcpc"}, src_pc, 1);
    chk({tag, "_retire"}, retire, 1);
    tick();
    chk({tag, "_cpi"}, cyc - start, 3);
    chk({tag, "_next"}, state, 0);
    $display("[TB] %s f3=%b zero=%b take=%0d", tag, fn3, z, exp_take);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; zero = 1'b0;
    set_ir(7'd0, 3'd0, 1'b0);
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {ir_wr_en, pc_wr_en, reg_wr_en, retire, mem_wr_en}, 0);
    chk("rst_selects", {src_addr, src_pc, src_a, src_b, src_rd}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_noready_ir", ir_wr_en, 0);
    $display("[TB] reset");

    // ALU class: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
    run_alu("addi",  OP_I, 3'b000, 1'b0, 3, 0, 1);
    run_alu("addi_b30", OP_I, 3'b000, 1'b1, 3, 0, 1);
    run_alu("sub",   OP_R, 3'b000, 1'b1, 2, 1, 0);
    run_alu("add",   OP_R, 3'b000, 1'b0, 2, 0, 0);
    run_alu("sll",   OP_R, 3'b001, 1'b0, 2, 2, 0);
    run_alu("slti",  OP_I, 3'b010, 1'b0, 3, 3, 1);
    run_alu("sltu",  OP_R, 3'b011, 1'b0, 2, 4, 0);
    run_alu("xori",  OP_I, 3'b100, 1'b0, 3, 5, 1);
    run_alu("srli",  OP_I, 3'b101, 1'b0, 3, 6, 1);
    run_alu("srai",  OP_I, 3'b101, 1'b1, 3, 7, 1);
    run_alu("sra",   OP_R, 3'b101, 1'b1, 2, 7, 0);
    run_alu("or",    OP_R, 3'b110, 1'b0, 2, 8, 0);
    run_alu("andi",  OP_I, 3'b111, 1'b0, 3, 9, 1);

    // lw with three wait cycles in MEM_RD
    set_ir(OP_LOAD, 3'b010, 1'b0);
    start = cyc;
    do_fetch("lw");
    do_decode("lw");
    ready = 1'b0;
    #1;
    chk("lw_adr_state", state, 4);
    chk("lw_adr_alu", alu_ctrl, 0);
    chk("lw_adr_ab", {src_a, src_b}, 1);
    chk("lw_adr_req", mem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", state, 5);
      chk("lw_wait_req", mem_req, 1);
      chk("lw_wait_addr", src_addr, 1);
      chk("lw_wait_wr", mem_wr_en, 0);
      chk("lw_wait_retire", retire, 0);
      tick();
    end
    ready = 1'b1;
    #1;
    chk("lw_rdy_state", state, 5);
    chk("lw_rdy_req", mem_req, 1);
    chk("lw_rdy_addr", src_addr, 1);
    tick();
    chk("lw_wb_state", state, 6);
    chk("lw_wb_reg", reg_wr_en, 1);
    chk("lw_wb_rd", src_rd, 1);
    chk("lw_wb_retire", retire, 1);
    chk("lw_wb_req", mem_req, 0);
    tick();
    chk("lw_cpi", cyc - start, 8);
    chk("lw_next", state, 0);
    $display("[TB] lw with 3 wait cycles");

    // sw with ready immediately
    set_ir(OP_STORE, 3'b010, 1'b0);
    start = cyc;
    do_fetch("sw");
    do_decode("sw");
    chk("sw_adr_state", state, 4);
    tick();
    chk("sw_state", state, 7);
    chk("sw_req", mem_req, 1);
    chk("sw_wr", mem_wr_en, 1);
    chk("sw_addr", src_addr, 1);
    chk("sw_retire", retire, 1);
    chk("sw_reg", reg_wr_en, 0);
    tick();
    chk("sw_cpi", cyc - start, 4);
    chk("sw_next", state, 0);
    $display("[TB] sw");

    run_br("beq_t",  3'b000, 1'b1, 1, 1);
    run_br("bne_nt", 3'b001, 1'b1, 1, 0);
    run_br("blt_t",  3'b100, 1'b0, 3, 1);
    run_br("bge_nt", 3'b101, 1'b0, 3, 0);
    run_br("bltu_nt", 3'b110, 1'b1, 4, 0);
    run_br("bgeu_t", 3'b111, 1'b1, 4, 1);

    // jal
    set_ir(OP_JAL, 3'b000, 1'b0);
    do_fetch("jal");
    do_decode("jal");
    chk("jal_state", state, 10);
    chk("jal_pc", {pc_wr_en, src_pc}, 3'b101);
    chk("jal_rd", {reg_wr_en, src_rd}, 3'b110);
    chk("jal_retire", retire, 1);
    tick();
    $display("[TB] jal");

    // jalr
    set_ir(OP_JALR, 3'b000, 1'b0);
    do_fetch("jalr");
    do_decode("jalr");
    chk("jalr_state", state, 11);
    chk("jalr_alu", {src_a, src_b, alu_ctrl}, 8'b00_01_0000);
    chk("jalr_pc", {pc_wr_en, src_pc}, 3'b110);
    chk("jalr_rd", {reg_wr_en, src_rd}, 3'b110);
    chk("jalr_retire", retire, 1);
    tick();
    $display("[TB] jalr");

    // lui
    set_ir(OP_LUI, 3'b000, 1'b0);
    do_fetch("lui");
    do_decode("lui");
    chk("lui_state", state, 12);
    chk("lui_rd", {reg_wr_en, src_rd}, 3'b111);
    chk("lui_pc", pc_wr_en, 0);
    chk("lui_retire", retire, 1);
    tick();
    chk("lui_next", state, 0);
    $display("[TB] lui");

    // auipc: OldPC + imm, then ALU writeback
    set_ir(OP_AUIPC, 3'b000, 1'b0);
    do_fetch("auipc");
    do_decode("auipc");
    chk("auipc_state", state, 13);
    chk("auipc_alu", {src_a, src_b, alu_ctrl}, 8'b01_01_0000);
    chk("auipc_retire", retire, 0);
    tick();
    chk("auipc_wb_state", state, 8);
    chk("auipc_wb_retire", retire, 1);
    tick();
    $display("[TB] auipc");

    // reset arrives together with ready during a store
    set_ir(OP_STORE, 3'b000, 1'b0);
    do_fetch("swrst");
    do_decode("swrst");
    tick();
    rst = 1'b1;
    #1;
    chk("swrst_state", state, 7);
    chk("swrst_retire", retire, 0);
    tick();
    rst = 1'b0;
    ready = 1'b0;
    #1;
    chk("swrst_after_state", state, 0);
    chk("swrst_after_wr", mem_wr_en, 0);
    chk("swrst_after_req", mem_req, 1);
    chk("swrst_after_err", err, 0);
    $display("[TB] reset during store");

    // illegal opcode
    set_ir(7'h7F, 3'b000, 1'b0);
    do_fetch("ill");
    do_decode("ill");
    chk("ill_state", state, 15);
    chk("ill_err", err, 1);
    chk("ill_req", mem_req, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("ill_hold_state", state, 15);
    chk("ill_hold_err", err, 1);
    chk("ill_hold_strobes", {mem_req, ir_wr_en, pc_wr_en, reg_wr_en, retire}, 0);
    rst = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("ill_rst_state", state, 0);
    chk("ill_rst_req", mem_req, 1);
    chk("ill_rst_err", err, 0);
    $display("[TB] illegal opcode");

    // illegal branch funct3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ir(OP_BRANCH, 3'b010, 1'b0);
    do_fetch("brill");
    do_decode("brill");
    chk("brill_state", state, 9);
    chk("brill_strobes", {pc_wr_en, retire}, 0);
    tick();
    chk("brill_err_state", state, 15);
    chk("brill_err", err, 1);
    $display("[TB] illegal branch funct3");

    // fetch timeout: ready never arrives, limit 4
    rst = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("to_wait_state", state, 0);
      chk("to_wait_ir", ir_wr_en, 0);
      chk("to_wait_err", err, 0);
      tick();
    end
    chk("to_state", state, 15);
    chk("to_err", err, 1);
    chk("to_req", mem_req, 0);
    $display("[TB] fetch timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
